uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  UART receive front end: baud-enable generator (8x oversample tick plus 1x bit tick) and
//  8-bit async serial receiver, 8N1 / 8E1 / 8O1. Sits between the pad-side rx pin and the
//  byte consumer. Delivers one byte per frame with a single-cycle rx_rdy strobe.
// PARAMETERS
//  OVS_DIV  4       clk cycles per oversample tick (rx_bd_en period), >=2
//  PARITY   "NONE"  "NONE" | "EVEN" | "ODD"; selects whether a parity bit precedes stop
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst         in   1  reset, asynchronous, active-high
//  rx          in   1  serial line, idle high, asynchronous to clk
//  rx_bd_en    out  1  1-clk pulse every OVS_DIV clks (8x oversample tick)
//  tx_bd_en    out  1  1-clk pulse every 8th rx_bd_en (1x bit tick), coincident with it
//  rx_data     out  8  last received byte, LSB first on line; holds until next good frame
//  rx_rdy      out  1  1-clk strobe: rx_data valid (new value visible same cycle)
//  parity_err  out  1  1-clk strobe with rx_rdy when parity bit mismatches
//  frame_err   out  1  1-clk strobe when stop bit sampled low
// BEHAVIOUR
//  Reset (async, rst=1): all outputs 0, div counters 0, state IDLE, rx synchroniser = 1.
//  Baud gen: clk counter 0..OVS_DIV-1; rx_bd_en=1 when count==OVS_DIV-1, then wraps to 0.
//   Tick counter 0..7 increments per rx_bd_en; tx_bd_en=1 on rx_bd_en with tick count==7.
//   First rx_bd_en OVS_DIV clks after reset release; free-running, never gated.
//  rx passes 2-flop synchroniser; receiver uses synchronised value only; acts on rx_bd_en.
//  FSM (all transitions on rx_bd_en cycles only):
//   IDLE : line low -> START, ovs cnt=0.
//   START: after 4 ticks (mid bit) re-sample; low -> DATA, high -> IDLE (glitch, no strobe).
//   DATA : sample every 8 ticks, shift in LSB first; after bit 7 -> PARITY or STOP.
//   PARITY (PARITY!="NONE"): sample at 8 ticks; EVEN: data^par must be 0; ODD: must be 1.
//   STOP : sample at 8 ticks. High: load rx_data, rx_rdy=1 (parity_err=1 if mismatch), ->IDLE.
//          Low: frame_err=1, rx_data unchanged, no rx_rdy -> BREAK.
//   BREAK: wait until line high on a tick -> IDLE.
//  Strobes high exactly one clk (the rx_bd_en cycle of stop sample), else 0.
//  Latency: rx_rdy ~ (0.5+9 or 10 bits)*8*OVS_DIV clks + 2-3 clk sync after start edge.
//  Back-to-back frames: new start edge accepted on first tick after stop sample.
//  Line low in IDLE continuously (break) re-triggers only after returning high.
//  Reset mid-frame: frame discarded, no strobe, FSM IDLE on release.
//  Tolerates +/-4% baud mismatch (sampling mid-bit of 8x grid).
// TESTING
//  1 Post-reset: rx=1 -> rx_bd_en every 4 clk, tx_bd_en every 32 clk, all other outputs 0.
//  2 PARITY=NONE, send 0x66 (start, 0,1,1,0,0,1,1,0, stop) at 32 clk/bit -> single rx_rdy,
//    rx_data=8'h66, parity_err=0, frame_err=0.
//  3 Back-to-back 0x00 then 0xFF, no idle gap -> two rx_rdy strobes, data 0x00 then 0xFF.
//  4 rx low for 8 clk only (glitch) -> FSM returns IDLE, no rx_rdy, no frame_err.
//  5 Frame 0xA5 with stop bit 0 -> frame_err pulse, no rx_rdy, rx_data keeps prior value;
//    next valid 0x3C received normally after line high.
//  6 PARITY=EVEN: 0x07 with par=1 -> rx_rdy, no err; with par=0 -> rx_rdy+parity_err.
//    Also assert rst mid-data -> no strobe, following frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// UART receive bundle: serial line in, baud ticks and received-byte strobes out.
// The receiver has no backpressure; the consumer must take rx_data on the rx_rdy cycle.
interface uart_rx_if;
   logic       rx;
   logic       rx_bd_en;
   logic       tx_bd_en;
   logic [7:0] rx_data;
   logic       rx_rdy;
   logic       parity_err;
   logic       frame_err;

   modport master (
      input  rx,
      output rx_bd_en, tx_bd_en, rx_data, rx_rdy, parity_err, frame_err
   );

   modport slave (
      output rx,
      input  rx_bd_en, tx_bd_en, rx_data, rx_rdy, parity_err, frame_err
   );
endinterface

// File: rtl/uart_rx_core.sv
// 8x-oversampled UART receiver with baud tick generator; byte strobed about 9.5-10.5 bit times after the start edge.
// No backpressure: rx_data holds until the next good frame and each strobe lasts one clk.
module uart_rx_core #(
   parameter int    OVS_DIV = 4,
   parameter string PARITY  = "NONE"
) (
   input logic      clk,
   input logic      rst,
   uart_rx_if.master bus
);
   localparam int CW      = (OVS_DIV > 2) ? $clog2(OVS_DIV) : 1;
   localparam bit HAS_PAR = (PARITY != "NONE");
   localparam bit ODD_PAR = (PARITY == "ODD");

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;

   logic [CW-1:0] clk_cnt;
   logic [2:0]    tick_cnt;
   logic          tick;
   logic          sync1, sync2;
   logic [2:0]    state;
   logic [2:0]    ovs_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          par_bit;

   // Internal tick lines up with the registered rx_bd_en pulse, so strobes coincide with it.
   assign tick = (clk_cnt == CW'(OVS_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_cnt      <= '0;
         tick_cnt     <= '0;
         bus.rx_bd_en <= 1'b0;
         bus.tx_bd_en <= 1'b0;
      end else begin
         clk_cnt      <= tick ? '0 : clk_cnt + 1'b1;
         bus.rx_bd_en <= tick;
         bus.tx_bd_en <= tick && (tick_cnt == 3'd7);
         if (tick)
            tick_cnt <= tick_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= bus.rx;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         ovs_cnt        <= '0;
         bit_cnt        <= '0;
         shift          <= '0;
         par_bit        <= 1'b0;
         bus.rx_data    <= '0;
         bus.rx_rdy     <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.frame_err  <= 1'b0;
      end else begin
         bus.rx_rdy     <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.frame_err  <= 1'b0;
         if (tick) begin
            case (state)
               S_IDLE: begin
                  if (!sync2) begin
                     state   <= S_START;
                     ovs_cnt <= '0;
                  end
               end
               S_START: begin
                  // Fourth tick after the edge lands mid start bit.
                  if (ovs_cnt == 3'd3) begin
                     ovs_cnt <= '0;
                     bit_cnt <= '0;
                     state   <= sync2 ? S_IDLE : S_DATA;
                  end else begin
                     ovs_cnt <= ovs_cnt + 3'd1;
                  end
               end
               S_DATA: begin
                  ovs_cnt <= ovs_cnt + 3'd1;
                  if (ovs_cnt == 3'd7) begin
                     shift   <= {sync2, shift[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7)
                        state <= HAS_PAR ? S_PARITY : S_STOP;
                  end
               end
               S_PARITY: begin
                  ovs_cnt <= ovs_cnt + 3'd1;
                  if (ovs_cnt == 3'd7) begin
                     par_bit <= sync2;
                     state   <= S_STOP;
                  end
               end
               S_STOP: begin
                  ovs_cnt <= ovs_cnt + 3'd1;
                  if (ovs_cnt == 3'd7) begin
                     if (sync2) begin
                        bus.rx_data    <= shift;
                        bus.rx_rdy     <= 1'b1;
                        bus.parity_err <= HAS_PAR && ((^shift ^ par_bit) != ODD_PAR);
                        state          <= S_IDLE;
                     end else begin
                        bus.frame_err <= 1'b1;
                        state         <= S_BREAK;
                     end
                  end
               end
               S_BREAK: begin
                  if (sync2)
                     state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboarded bench for uart_rx_core: one 8N1 instance and one 8E1 instance on separate lines.
// Expected frames are queued when driven and matched against each rx_rdy / frame_err strobe.
module tb_uart_rx_core;
   localparam int BIT_CLKS = 32;

   typedef struct {
      bit         kind;   // 0 = good byte, 1 = framing error
      logic [7:0] data;
      bit         perr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t q_n[$];
   exp_t q_e[$];
   logic [7:0] last_n = 8'h00;
   logic [7:0] last_e = 8'h00;

   uart_rx_if bus_n ();
   uart_rx_if bus_e ();

   uart_rx_core #(.OVS_DIV(4), .PARITY("NONE")) dut_n (.clk(clk), .rst(rst), .bus(bus_n));
   uart_rx_core #(.OVS_DIV(4), .PARITY("EVEN")) dut_e (.clk(clk), .rst(rst), .bus(bus_e));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic score(input bit sel, input bit rdy, input bit ferr, input bit perr,
                        input logic [7:0] d);
      exp_t e;
      string pfx = sel ? "even" : "none";
      if ((sel ? q_e.size() : q_n.size()) == 0) begin
         check({pfx, "_unexpected_strobe"}, {29'd0, rdy, ferr, perr}, 32'd0);
      end else begin
         e = sel ? q_e.pop_front() : q_n.pop_front();
         check({pfx, "_frame_err"}, {31'd0, ferr}, {31'd0, e.kind});
         check({pfx, "_rx_rdy"},    {31'd0, rdy},  {31'd0, !e.kind});
         check({pfx, "_rx_data"},   {24'd0, d},    {24'd0, e.data});
         check({pfx, "_parity_err"}, {31'd0, perr}, {31'd0, e.perr});
      end
   endtask

   always @(negedge clk)
      if (!rst && (bus_n.rx_rdy || bus_n.frame_err || bus_n.parity_err))
         score(1'b0, bus_n.rx_rdy, bus_n.frame_err, bus_n.parity_err, bus_n.rx_data);

   always @(negedge clk)
      if (!rst && (bus_e.rx_rdy || bus_e.frame_err || bus_e.parity_err))
         score(1'b1, bus_e.rx_rdy, bus_e.frame_err, bus_e.parity_err, bus_e.rx_data);

   task automatic set_line(input bit sel, input bit v);
      if (sel) bus_e.rx = v;
      else     bus_n.rx = v;
   endtask

   task automatic drive_bit(input bit sel, input bit v);
      set_line(sel, v);
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      repeat (n * BIT_CLKS) @(negedge clk);
   endtask

   task automatic send(input bit sel, input logic [7:0] d, input bit hp, input bit par,
                       input bit stop);
      exp_t e;
      e.kind = !stop;
      e.data = stop ? d : (sel ? last_e : last_n);
      e.perr = stop && hp && ((^d ^ par) != 1'b0);
      if (sel) q_e.push_back(e);
      else     q_n.push_back(e);
      if (stop) begin
         if (sel) last_e = d;
         else     last_n = d;
      end
      drive_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
      if (hp) drive_bit(sel, par);
      drive_bit(sel, stop);
      set_line(sel, 1'b1);
   endtask

   initial begin
      int rx_cnt, tx_cnt, rx_bad, tx_bad, other_bad;
      bus_n.rx = 1'b1;
      bus_e.rx = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {18'd0, bus_n.rx_bd_en, bus_n.tx_bd_en, bus_n.rx_data, bus_n.rx_rdy,
             bus_n.parity_err, bus_n.frame_err, bus_e.rx_rdy}, 32'd0);
      rst = 1'b0;

      // Baud ticks: rx_bd_en after edges 4,8,..; tx_bd_en after edges 32,64.
      rx_cnt = 0; tx_cnt = 0; rx_bad = 0; tx_bad = 0; other_bad = 0;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (bus_n.rx_bd_en) rx_cnt++;
         if (bus_n.tx_bd_en) tx_cnt++;
         if (bus_n.rx_bd_en !== ((k % 4) == 0)) rx_bad++;
         if (bus_n.tx_bd_en !== ((k % 32) == 0)) tx_bad++;
         if ({bus_n.rx_data, bus_n.rx_rdy, bus_n.parity_err, bus_n.frame_err} !== 11'd0) other_bad++;
      end
      check("rx_bd_en_count", rx_cnt, 16);
      check("tx_bd_en_count", tx_cnt, 2);
      check("rx_bd_en_phase_errs", rx_bad, 0);
      check("tx_bd_en_phase_errs", tx_bad, 0);
      check("idle_outputs_nonzero", other_bad, 0);

      send(1'b0, 8'h66, 1'b0, 1'b0, 1'b1);
      idle_bits(2);

      send(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      send(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
      idle_bits(2);

      bus_n.rx = 1'b0;
      repeat (8) @(negedge clk);
      bus_n.rx = 1'b1;
      idle_bits(3);
      check("glitch_data_kept", {24'd0, bus_n.rx_data}, 32'h0000_00FF);

      send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
      idle_bits(2);
      check("ferr_data_kept", {24'd0, bus_n.rx_data}, 32'h0000_00FF);
      send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
      idle_bits(2);

      send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
      send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
      idle_bits(2);

      // Reset in the middle of a data byte: nothing may be delivered for it.
      bus_e.rx = 1'b0;
      idle_bits(4);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("midframe_reset_data", {24'd0, bus_e.rx_data}, 32'd0);
      bus_e.rx = 1'b1;
      rst = 1'b0;
      last_e = 8'h00;
      idle_bits(12);
      send(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
      idle_bits(3);

      check("none_queue_left", q_n.size(), 0);
      check("even_queue_left", q_e.size(), 0);
      check("final_even_data", {24'd0, bus_e.rx_data}, 32'h0000_005A);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
